// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and data load/store.
// Optional starvation guard for fetch is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sys_reset,
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   output logic        i_busy_o,
   output logic        i_rvalid_o,
   output logic [31:0] i_rdata_o,
   input  logic        d_en_i,
   input  logic [3:0]  d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_busy_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        mem_en_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_busy_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("mem_port_arbiter: STARVE_LIMIT out of range 1..255");
   end

   grant_t grant;
   owner_t owner_r;
   owner_t owner_nxt;
   logic   in_reset;
   logic   guard;
   logic   i_acc;
   logic   d_acc;
   logic   unused_addr_lsb;

   assign in_reset        = sys_reset | ~reset_n;
   assign unused_addr_lsb = ^i_addr_i[1:0];

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign guard = i_req_i && (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Counts denied fetch cycles; a busy memory keeps the count so forced priority persists.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (sys_reset || !i_req_i || i_acc) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
`else
   assign guard = 1'b0;
`endif

   // Grant selection: forced fetch, else data over instruction.
   always_comb begin
      grant = GNT_NONE;
      if (!in_reset) begin
         if (guard) begin
            grant = GNT_I;
         end else if (d_en_i) begin
            grant = GNT_D;
         end else if (i_req_i) begin
            grant = GNT_I;
         end
      end
   end

   assign i_acc = (grant == GNT_I) && !mem_busy_i;
   assign d_acc = (grant == GNT_D) && !mem_busy_i;

   assign i_busy_o = !i_acc;
   assign d_busy_o = d_en_i && !d_acc;

   // Shared memory bus mux.
   always_comb begin
      mem_en_o    = (grant != GNT_NONE);
      mem_we_o    = 4'b0000;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (grant == GNT_D) begin
         mem_we_o    = d_we_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end else if (grant == GNT_I) begin
         mem_addr_o  = {i_addr_i[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_r <= OWN_NONE;
      end else begin
         owner_r <= owner_nxt;
      end
   end

   // Response owner follows the read accepted this cycle.
   always_comb begin
      owner_nxt = OWN_NONE;
      if (!sys_reset) begin
         if (i_acc) begin
            owner_nxt = OWN_I;
         end else if (d_acc && (d_we_i == 4'b0000)) begin
            owner_nxt = OWN_D;
         end
      end
   end

   assign i_rvalid_o = (owner_r == OWN_I) && !in_reset;
   assign d_rvalid_o = (owner_r == OWN_D) && !in_reset;
   assign i_rdata_o  = mem_rdata_i;
   assign d_rdata_o  = mem_rdata_i;

endmodule
